// File: rtl/pacman_pkg.sv
// Shared definitions for the video RAM arbiter: default widths and the
// CPU-side handshake state encoding.
package pacman_pkg;

    localparam int DEF_ADDR_W       = 12;
    localparam int DEF_DATA_W       = 8;
    localparam int DEF_STARVE_LIMIT = 1024;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PEND   = 2'd1,
        FLIGHT = 2'd2,
        ACK    = 2'd3
    } cpu_state_e;

endpackage : pacman_pkg

// File: rtl/vram_arbiter.sv
// Single-port video RAM arbiter: the display pipeline always owns the RAM port
// when it asks; the CPU gets the port in the first cycle the display leaves free.
module vram_arbiter
    import pacman_pkg::*;
#(
    parameter int ADDR_W       = DEF_ADDR_W,
    parameter int DATA_W       = DEF_DATA_W,
    parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              disp_req,
    input  logic [ADDR_W-1:0] disp_addr,
    output logic              disp_valid,
    output logic [DATA_W-1:0] disp_rdata,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_starved,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int              CNT_W   = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(STARVE_LIMIT);
    localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

    cpu_state_e        r_state;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [CNT_W-1:0]  r_wait_cnt;
    logic              r_disp_p1;
    logic              w_issue;

    // A CPU op is issued only in a PEND cycle the display leaves free, never during reset.
    assign w_issue = (r_state == PEND) && !disp_req && !reset;

    // RAM port mux: display wins; otherwise the port shows the latched CPU op.
    always_comb begin
        mem_addr  = r_addr;
        mem_wdata = r_wdata;
        mem_we    = 1'b0;
        if (disp_req) begin
            mem_addr = disp_addr;
        end else if (w_issue) begin
            mem_we = r_we;
        end else begin
            mem_we = 1'b0;
        end
    end

    // Display read pipeline: address in N, data captured in N+1, valid in N+2.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_disp_p1  <= 1'b0;
            disp_valid <= 1'b0;
            disp_rdata <= {DATA_W{1'b0}};
        end else begin
            r_disp_p1  <= disp_req;
            disp_valid <= r_disp_p1;
            if (r_disp_p1) begin
                disp_rdata <= mem_rdata;
            end else begin
                disp_rdata <= disp_rdata;
            end
        end
    end

    // CPU four-phase handshake FSM with wait counter and sticky starvation flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_we        <= 1'b0;
            r_addr      <= {ADDR_W{1'b0}};
            r_wdata     <= {DATA_W{1'b0}};
            r_wait_cnt  <= {CNT_W{1'b0}};
            cpu_ack     <= 1'b0;
            cpu_rdata   <= {DATA_W{1'b0}};
            cpu_starved <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (cpu_req) begin
                        r_we       <= cpu_we;
                        r_addr     <= cpu_addr;
                        r_wdata    <= cpu_wdata;
                        r_wait_cnt <= {CNT_W{1'b0}};
                        r_state    <= PEND;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                PEND: begin
                    if (!disp_req) begin
                        r_state <= FLIGHT;
                    end else begin
                        if (r_wait_cnt != LIMIT_C) begin
                            r_wait_cnt <= r_wait_cnt + ONE_C;
                        end else begin
                            r_wait_cnt <= r_wait_cnt;
                        end
                        // Flag in the same cycle the counter lands on the limit.
                        if (r_wait_cnt >= (LIMIT_C - ONE_C)) begin
                            cpu_starved <= 1'b1;
                        end else begin
                            cpu_starved <= cpu_starved;
                        end
                        r_state <= PEND;
                    end
                end
                FLIGHT: begin
                    if (!r_we) begin
                        cpu_rdata <= mem_rdata;
                    end else begin
                        cpu_rdata <= cpu_rdata;
                    end
                    cpu_ack <= 1'b1;
                    r_state <= ACK;
                end
                ACK: begin
                    if (!cpu_req) begin
                        cpu_ack <= 1'b0;
                        r_state <= IDLE;
                    end else begin
                        cpu_ack <= 1'b1;
                        r_state <= ACK;
                    end
                end
                default: begin
                    cpu_ack <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule : vram_arbiter

// File: tb/tb_vram_arbiter.sv
// Self-checking bench for vram_arbiter: a cycle-indexed plan of stimulus and
// expectations is built from the arbitration rules, then replayed against the DUT.
module tb_vram_arbiter;

    localparam int NC    = 1800;
    localparam int NA    = 2048;
    localparam int LIMIT = 16;

    logic        clk;
    logic        reset;
    logic        disp_req;
    logic [11:0] disp_addr;
    logic        disp_valid;
    logic [7:0]  disp_rdata;
    logic        cpu_req;
    logic        cpu_we;
    logic [11:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    logic        cpu_ack;
    logic [7:0]  cpu_rdata;
    logic        cpu_starved;
    logic [11:0] mem_addr;
    logic        mem_we;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;

    vram_arbiter #(
        .ADDR_W       (12),
        .DATA_W       (8),
        .STARVE_LIMIT (LIMIT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .disp_req    (disp_req),
        .disp_addr   (disp_addr),
        .disp_valid  (disp_valid),
        .disp_rdata  (disp_rdata),
        .cpu_req     (cpu_req),
        .cpu_we      (cpu_we),
        .cpu_addr    (cpu_addr),
        .cpu_wdata   (cpu_wdata),
        .cpu_ack     (cpu_ack),
        .cpu_rdata   (cpu_rdata),
        .cpu_starved (cpu_starved),
        .mem_addr    (mem_addr),
        .mem_we      (mem_we),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // External synchronous RAM; port values captured mid-cycle to stay clear of the edge.
    logic [7:0]  ram [4096];
    logic        q_we;
    logic [11:0] q_a;
    logic [7:0]  q_d;
    initial begin
        for (int i = 0; i < 4096; i++) ram[i] = i[7:0];
    end
    always @(negedge clk) begin
        q_we <= mem_we;
        q_a  <= mem_addr;
        q_d  <= mem_wdata;
    end
    always @(posedge clk) begin
        if (q_we === 1'b1) ram[q_a] <= q_d;
        mem_rdata <= ram[q_a];
    end

    // Stimulus plan
    bit        s_rst [NA];
    bit        s_dreq [NA];
    bit [11:0] s_daddr [NA];
    bit        s_creq [NA];
    bit        s_cwe [NA];
    bit [11:0] s_caddr [NA];
    bit [7:0]  s_cwd [NA];
    // Transaction events
    bit        p_latch [NA];
    bit [11:0] p_la [NA];
    bit [7:0]  p_ld [NA];
    bit        p_wr [NA];
    bit        p_rd [NA];
    bit [11:0] p_addr [NA];
    bit [7:0]  p_wd [NA];
    int        p_rd_hi [NA];
    bit        p_starve [NA];
    // Expected outputs per cycle
    bit        e_we [NA];
    bit        e_chk_ma [NA];
    bit [11:0] e_ma [NA];
    bit        e_chk_mwd [NA];
    bit [7:0]  e_mwd [NA];
    bit        e_dv [NA];
    bit [7:0]  e_dd [NA];
    bit        e_ack [NA];
    bit        e_rd_chk [NA];
    bit [7:0]  e_rd [NA];
    bit        e_starv [NA];
    bit        e_rstchk [NA];
    bit [7:0]  gold [4096];

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s cycle %0d: observed %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    // One CPU transaction: request raised in cycle c, granted the first cycle the display is idle.
    task automatic plan_cpu(input int c, input bit we, input bit [11:0] a, input bit [7:0] d,
                            input int hold, input bit rst_flight, output int nxt);
        int iss;
        int drop;
        iss = c + 1;
        while (s_dreq[iss] && iss < NA - 8) iss++;
        s_cwe[c]   = we;
        s_caddr[c] = a;
        s_cwd[c]   = d;
        p_latch[c+1] = 1'b1;
        p_la[c+1]    = a;
        p_ld[c+1]    = d;
        if (iss - (c + 1) >= LIMIT) p_starve[c+1+LIMIT] = 1'b1;
        p_addr[iss] = a;
        p_wd[iss]   = d;
        p_wr[iss]   = we;
        if (rst_flight) begin
            s_rst[iss+1] = 1'b1;
            drop = iss + 2;
        end else begin
            drop = iss + 2 + hold + 1;
            for (int k = iss + 2; k <= drop; k++) e_ack[k] = 1'b1;
            if (!we) begin
                p_rd[iss]    = 1'b1;
                p_rd_hi[iss] = drop;
            end
        end
        for (int k = c; k < drop; k++) s_creq[k] = 1'b1;
        for (int k = c + 1; k < drop; k++) begin
            s_cwe[k]   = 1'($urandom_range(0, 1));
            s_caddr[k] = 12'($urandom);
            s_cwd[k]   = 8'($urandom);
        end
        nxt = drop + 1;
    endtask

    initial begin
        int  nxt;
        int  cur;
        bit  st;
        bit  lv;
        bit [11:0] la;
        bit [7:0]  ld;

        reset = 1'b1; disp_req = 1'b0; disp_addr = 12'h000;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 12'h000; cpu_wdata = 8'h00;

        // Power-on reset
        for (int t = 0; t < 3; t++) s_rst[t] = 1'b1;
        // Display-only burst 0x010..0x013
        for (int i = 0; i < 4; i++) begin
            s_dreq[5+i]  = 1'b1;
            s_daddr[5+i] = 12'h010 + 12'(i);
        end
        // CPU write 0x5A to 0x123, then read it back
        plan_cpu(15, 1'b1, 12'h123, 8'h5A, 0, 1'b0, nxt);
        plan_cpu(nxt + 1, 1'b0, 12'h123, 8'h00, 1, 1'b0, nxt);
        // Contention: display busy 10 cycles while a write is pending
        for (int i = 0; i < 10; i++) begin
            s_dreq[40+i]  = 1'b1;
            s_daddr[40+i] = 12'h010 + 12'(i);
        end
        plan_cpu(40, 1'b1, 12'h011, 8'hA7, 0, 1'b0, nxt);
        s_dreq[56]  = 1'b1;
        s_daddr[56] = 12'h011;
        // Starvation: display busy 20 cycles with a read pending
        for (int i = 0; i < 20; i++) begin
            s_dreq[70+i]  = 1'b1;
            s_daddr[70+i] = 12'h020 + 12'(i);
        end
        plan_cpu(70, 1'b0, 12'h011, 8'h00, 0, 1'b0, nxt);
        // Request held 5 cycles past ack
        plan_cpu(100, 1'b1, 12'h124, 8'h3C, 5, 1'b0, nxt);
        // Reset during FLIGHT of a read, then a normal read
        s_dreq[119] = 1'b1; s_daddr[119] = 12'h030;
        s_dreq[121] = 1'b1; s_daddr[121] = 12'h031;
        plan_cpu(118, 1'b0, 12'h123, 8'h00, 0, 1'b1, nxt);
        plan_cpu(126, 1'b0, 12'h124, 8'h00, 0, 1'b0, nxt);
        // Reset with display reads in flight
        s_dreq[140] = 1'b1; s_daddr[140] = 12'h005;
        s_dreq[141] = 1'b1; s_daddr[141] = 12'h006;
        s_rst[141]  = 1'b1;
        // Randomized traffic
        for (int t = 160; t < NC - 5; t++) begin
            s_dreq[t]  = ($urandom_range(0, 99) < 40);
            s_daddr[t] = 12'h100 + 12'($urandom_range(0, 31));
        end
        cur = 162;
        while (cur < NC - 60) begin
            plan_cpu(cur + int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                     12'h100 + 12'($urandom_range(0, 31)), 8'($urandom),
                     int'($urandom_range(0, 3)), 1'b0, cur);
        end

        // Derive expected outputs in time order from a reference memory image
        for (int i = 0; i < 4096; i++) gold[i] = i[7:0];
        st = 1'b0; lv = 1'b0; la = 12'h000; ld = 8'h00;
        for (int t = 0; t < NC; t++) begin
            if (t > 0 && s_rst[t-1]) begin
                lv = 1'b0;
                st = 1'b0;
                e_rstchk[t] = 1'b1;
            end
            if (p_latch[t]) begin
                lv = 1'b1; la = p_la[t]; ld = p_ld[t];
            end
            e_chk_ma[t]  = s_dreq[t] || lv;
            e_ma[t]      = s_dreq[t] ? s_daddr[t] : la;
            e_chk_mwd[t] = lv;
            e_mwd[t]     = ld;
            e_we[t]      = p_wr[t] && !s_rst[t];
            if (s_dreq[t] && !s_rst[t] && !s_rst[t+1]) begin
                e_dv[t+2] = 1'b1;
                e_dd[t+2] = gold[s_daddr[t]];
            end
            if (p_rd[t]) begin
                for (int k = t + 2; k <= p_rd_hi[t]; k++) begin
                    e_rd_chk[k] = 1'b1;
                    e_rd[k]     = gold[p_addr[t]];
                end
            end
            if (e_we[t]) gold[p_addr[t]] = p_wd[t];
            if (p_starve[t]) st = 1'b1;
            e_starv[t] = st;
        end

        // Replay the plan and compare every cycle
        for (int t = 0; t < NC; t++) begin
            @(posedge clk);
            #1;
            cyc       = t;
            reset     = s_rst[t];
            disp_req  = s_dreq[t];
            disp_addr = s_daddr[t];
            cpu_req   = s_creq[t];
            cpu_we    = s_cwe[t];
            cpu_addr  = s_caddr[t];
            cpu_wdata = s_cwd[t];
            #3;
            chk("mem_we", 32'(mem_we), 32'(e_we[t]));
            if (t > 0) begin
                if (e_chk_ma[t])  chk("mem_addr", 32'(mem_addr), 32'(e_ma[t]));
                if (e_chk_mwd[t]) chk("mem_wdata", 32'(mem_wdata), 32'(e_mwd[t]));
                chk("disp_valid", 32'(disp_valid), 32'(e_dv[t]));
                if (e_dv[t])      chk("disp_rdata", 32'(disp_rdata), 32'(e_dd[t]));
                chk("cpu_ack", 32'(cpu_ack), 32'(e_ack[t]));
                if (e_rd_chk[t])  chk("cpu_rdata", 32'(cpu_rdata), 32'(e_rd[t]));
                chk("cpu_starved", 32'(cpu_starved), 32'(e_starv[t]));
                if (e_rstchk[t]) begin
                    chk("rst_disp_rdata", 32'(disp_rdata), 32'h0);
                    chk("rst_cpu_rdata", 32'(cpu_rdata), 32'h0);
                end
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule : tb_vram_arbiter
